rotor_stage: RTL and testbench

- Parametrised, stateful Enigma rotor unit. It replaces a fixed 64-way combinational wiring mux.
- Holds a loadable wiring permutation and its inverse, a rotor position and a notch.
- Performs forward or backward substitution offset by the position, with a one-cycle registered valid/ready output.
- Steps on command and emits a carry pulse at the notch. Instances are chained: the carry_out of one stage drives the step_in of the next.

---
 rtl/enigma_pkg.sv | 8 +
 rtl/rotor_mod_addsub.sv | 19 +
 rtl/rotor_stage.sv | 77 +++++++
 tb/tb_rotor_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared defaults, direction encodings and symbol type for rotor stages
package enigma_pkg;
    localparam int DEF_SYM_W = 6;
    localparam int DEF_ALPHA_N = 64;
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;
    typedef logic [DEF_SYM_W-1:0] sym_t;
endpackage

// File: rtl/rotor_mod_addsub.sv
// rotor_mod_addsub: (a + b) or (a - b) modulo ALPHA_N for operands already below ALPHA_N
module rotor_mod_addsub import enigma_pkg::*; #(
    parameter int SYM_W = DEF_SYM_W,
    parameter int ALPHA_N = DEF_ALPHA_N
) (
    input  logic [SYM_W-1:0] a,
    input  logic [SYM_W-1:0] b,
    input  logic             sub,
    output logic [SYM_W-1:0] y
);
    localparam logic [SYM_W:0] MOD = (SYM_W+1)'(ALPHA_N);
    logic [SYM_W:0] raw;
    // the extra bit is the borrow on subtract and the overflow headroom on add
    always_comb begin
        raw = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
        y = sub ? (raw[SYM_W] ? SYM_W'(raw + MOD) : raw[SYM_W-1:0])
                : (raw >= MOD ? SYM_W'(raw - MOD) : raw[SYM_W-1:0]);
    end
endmodule

// File: rtl/rotor_stage.sv
// rotor_stage: loadable Enigma rotor with position offset, stepping/carry and a one-deep output register
module rotor_stage import enigma_pkg::*; #(
    parameter int SYM_W = DEF_SYM_W,
    parameter int ALPHA_N = DEF_ALPHA_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_wire_we,
    input  logic [SYM_W-1:0] cfg_addr,
    input  logic [SYM_W-1:0] cfg_data,
    input  logic             cfg_pos_we,
    input  logic             cfg_notch_we,
    input  logic [SYM_W-1:0] cfg_val,
    input  logic             step_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_dir,
    input  logic [SYM_W-1:0] in_sym,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_sym,
    output logic             out_err,
    output logic             carry_out,
    output logic [SYM_W-1:0] pos
);
    localparam logic [SYM_W:0] MOD = (SYM_W+1)'(ALPHA_N);
    localparam logic [SYM_W-1:0] LAST = SYM_W'(ALPHA_N - 1);
    logic [SYM_W-1:0] fwd [ALPHA_N];
    logic [SYM_W-1:0] inv [ALPHA_N];
    logic [SYM_W-1:0] notch, entry, tabVal, exitSym;
    logic symOk, wireOk, valOk, accept, posLoad;
    always_comb begin
        symOk = {1'b0, in_sym} < MOD;
        wireOk = cfg_wire_we && ({1'b0, cfg_addr} < MOD) && ({1'b0, cfg_data} < MOD);
        valOk = {1'b0, cfg_val} < MOD;
        posLoad = cfg_pos_we && valOk;
        in_ready = !out_valid || out_ready;
        accept = in_valid && in_ready;
        // an out-of-range symbol never indexes the tables
        tabVal = !symOk ? '0 : (in_dir == DIR_FWD ? fwd[entry] : inv[entry]);
    end
    rotor_mod_addsub #(.SYM_W(SYM_W), .ALPHA_N(ALPHA_N)) uEntry (
        .a(in_sym), .b(pos), .sub(1'b0), .y(entry)
    );
    rotor_mod_addsub #(.SYM_W(SYM_W), .ALPHA_N(ALPHA_N)) uExit (
        .a(tabVal), .b(pos), .sub(1'b1), .y(exitSym)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ALPHA_N; i++) begin
                fwd[i] <= SYM_W'(i);
                inv[i] <= SYM_W'(i);
            end
            pos <= '0;
            notch <= LAST;
            out_valid <= 1'b0;
            out_sym <= '0;
            out_err <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            if (wireOk) begin
                fwd[cfg_addr] <= cfg_data;
                inv[cfg_data] <= cfg_addr;
            end
            if (posLoad) pos <= cfg_val;
            else if (step_in) pos <= pos == LAST ? '0 : pos + SYM_W'(1);
            if (cfg_notch_we && valOk) notch <= cfg_val;
            // a position load swallows the step, so it cannot carry either
            carry_out <= step_in && !posLoad && pos == notch;
            if (accept) begin
                out_valid <= 1'b1;
                out_sym <= symOk ? exitSym : '0;
                out_err <= !symOk;
            end else if (out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rotor_stage.sv
// tb_rotor_stage: directed and randomized checks of rotor_stage against an arithmetic rotor model
module tb_rotor_stage;
    import enigma_pkg::*;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic aRst, aWireWe, aPosWe, aNotchWe, aStep, aInValid, aInReady, aDir;
    logic aOutValid, aOutReady, aErr, aCarry;
    sym_t aAddr, aData, aVal, aSym, aOutSym, aPos;
    logic bRst, bWireWe, bPosWe, bNotchWe, bStep, bInValid, bInReady, bDir;
    logic bOutValid, bOutReady, bErr, bCarry;
    logic [4:0] bAddr, bData, bVal, bSym, bOutSym, bPos;

    rotor_stage dutA (
        .clk(clk), .rst_n(aRst), .cfg_wire_we(aWireWe), .cfg_addr(aAddr), .cfg_data(aData),
        .cfg_pos_we(aPosWe), .cfg_notch_we(aNotchWe), .cfg_val(aVal), .step_in(aStep),
        .in_valid(aInValid), .in_ready(aInReady), .in_dir(aDir), .in_sym(aSym),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_sym(aOutSym), .out_err(aErr),
        .carry_out(aCarry), .pos(aPos)
    );
    rotor_stage #(.SYM_W(5), .ALPHA_N(26)) dutB (
        .clk(clk), .rst_n(bRst), .cfg_wire_we(bWireWe), .cfg_addr(bAddr), .cfg_data(bData),
        .cfg_pos_we(bPosWe), .cfg_notch_we(bNotchWe), .cfg_val(bVal), .step_in(bStep),
        .in_valid(bInValid), .in_ready(bInReady), .in_dir(bDir), .in_sym(bSym),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_sym(bOutSym), .out_err(bErr),
        .carry_out(bCarry), .pos(bPos)
    );

    int nComp = 0;
    int nFail = 0;
    int mFwd[64];
    int mInv[64];
    int mPos, mNotch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nComp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // rotor as a cipher: shift in by position, substitute, shift back out
    function automatic int refOut(input int sym, input logic dir, input int p);
        int e, t;
        e = (sym + p) % 64;
        t = dir ? mInv[e] : mFwd[e];
        return (t - p + 64) % 64;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setWire(input int a, input int d);
        aWireWe = 1'b1; aAddr = sym_t'(a); aData = sym_t'(d);
        tick();
        aWireWe = 1'b0;
        mFwd[a] = d;
        mInv[d] = a;
    endtask

    task automatic setPos(input int v);
        aPosWe = 1'b1; aVal = sym_t'(v);
        tick();
        aPosWe = 1'b0;
        mPos = v;
    endtask

    task automatic setNotch(input int v);
        aNotchWe = 1'b1; aVal = sym_t'(v);
        tick();
        aNotchWe = 1'b0;
        mNotch = v;
    endtask

    task automatic lookup(input string tag, input int sym, input logic dir);
        int exp;
        exp = refOut(sym, dir, mPos);
        aInValid = 1'b1; aSym = sym_t'(sym); aDir = dir;
        #1;
        chk({tag, "_rdy"}, aInReady, 1);
        tick();
        aInValid = 1'b0;
        chk({tag, "_vld"}, aOutValid, 1);
        chk({tag, "_sym"}, aOutSym, exp);
        chk({tag, "_err"}, aErr, 0);
    endtask

    task automatic stepA(input string tag, input int expCarry);
        aStep = 1'b1;
        tick();
        aStep = 1'b0;
        mPos = (mPos + 1) % 64;
        chk({tag, "_pos"}, aPos, mPos);
        chk({tag, "_carry"}, aCarry, expCarry);
    endtask

    task automatic bLook(input string tag, input int sym, input logic dir, input int expSym, input int expErr);
        bInValid = 1'b1; bSym = 5'(sym); bDir = dir;
        tick();
        bInValid = 1'b0;
        chk({tag, "_vld"}, bOutValid, 1);
        chk({tag, "_sym"}, bOutSym, expSym);
        chk({tag, "_err"}, bErr, expErr);
    endtask

    initial begin
        int perm[64];
        int exp[8];
        int e1, e2, j, tmp, sym, stp;
        logic dir;
        aRst = 1'b0; aWireWe = 0; aPosWe = 0; aNotchWe = 0; aStep = 0; aInValid = 0; aDir = 0;
        aAddr = '0; aData = '0; aVal = '0; aSym = '0; aOutReady = 1'b1;
        bRst = 1'b0; bWireWe = 0; bPosWe = 0; bNotchWe = 0; bStep = 0; bInValid = 0; bDir = 0;
        bAddr = '0; bData = '0; bVal = '0; bSym = '0; bOutReady = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mFwd[i] = i;
            mInv[i] = i;
        end
        mPos = 0;
        mNotch = 63;
        tick();
        tick();
        chk("rst_vld", aOutValid, 0);
        chk("rst_sym", aOutSym, 0);
        chk("rst_err", aErr, 0);
        chk("rst_carry", aCarry, 0);
        chk("rst_pos", aPos, 0);
        aRst = 1'b1; bRst = 1'b1;
        tick();
        chk("rst_rdy", aInReady, 1);
        lookup("ident5", 5, DIR_FWD);
        tick();
        chk("idle_vld", aOutValid, 0);

        for (int i = 0; i < 64; i++) setWire(i, (i + 3) % 64);
        lookup("shift_f10", 10, DIR_FWD);
        chk("shift_f10_val", aOutSym, 13);
        lookup("shift_b13", 13, DIR_BWD);
        chk("shift_b13_val", aOutSym, 10);
        lookup("shift_b1", 1, DIR_BWD);
        chk("shift_b1_val", aOutSym, 62);
        setPos(2);
        chk("pos2", aPos, 2);
        lookup("pos2_f62", 62, DIR_FWD);
        chk("pos2_f62_val", aOutSym, 1);
        lookup("pos2_b1", 1, DIR_BWD);
        chk("pos2_b1_val", aOutSym, 62);

        setNotch(63);
        setPos(63);
        stepA("wrap", 1);
        tick();
        chk("wrap_pulse_end", aCarry, 0);
        setPos(5);
        stepA("nonotch", 0);
        aPosWe = 1'b1; aVal = sym_t'(10); aStep = 1'b1;
        tick();
        aPosWe = 1'b0; aStep = 1'b0; mPos = 10;
        chk("posload_pos", aPos, 10);
        chk("posload_carry", aCarry, 0);
        aNotchWe = 1'b1; aVal = sym_t'(20); aStep = 1'b1;
        tick();
        aNotchWe = 1'b0; aStep = 1'b0; mPos = 11;
        chk("oldnotch_carry", aCarry, 0);
        chk("oldnotch_pos", aPos, 11);
        setNotch(11);
        stepA("newnotch", 1);

        // random permutation, random notch, lookups racing random steps
        for (int i = 0; i < 64; i++) perm[i] = i;
        for (int i = 63; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int i = 0; i < 64; i++) setWire(i, perm[i]);
        setNotch(int'($urandom_range(7, 0)));
        setPos(0);
        for (int k = 0; k < 40; k++) begin
            sym = int'($urandom_range(63, 0));
            dir = 1'($urandom_range(1, 0));
            stp = int'($urandom_range(1, 0));
            e1 = refOut(sym, dir, mPos);
            e2 = (stp == 1 && mPos == mNotch) ? 1 : 0;
            aInValid = 1'b1; aSym = sym_t'(sym); aDir = dir; aStep = 1'(stp);
            tick();
            if (stp == 1) mPos = (mPos + 1) % 64;
            chk("rnd_sym", aOutSym, e1);
            chk("rnd_carry", aCarry, e2);
            chk("rnd_pos", aPos, mPos);
        end
        aInValid = 1'b0; aStep = 1'b0;
        tick();

        aOutReady = 1'b0;
        e1 = refOut(33, DIR_FWD, mPos);
        lookup("bp_first", 33, DIR_FWD);
        e2 = refOut(7, DIR_BWD, mPos);
        aInValid = 1'b1; aSym = sym_t'(7); aDir = DIR_BWD;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_rdy", aInReady, 0);
            tick();
            chk("bp_vld", aOutValid, 1);
            chk("bp_hold", aOutSym, e1);
        end
        aOutReady = 1'b1;
        #1;
        chk("bp_release_rdy", aInReady, 1);
        tick();
        chk("bp_next_vld", aOutValid, 1);
        chk("bp_next_sym", aOutSym, e2);

        for (int k = 0; k < 8; k++) begin
            sym = int'($urandom_range(63, 0));
            dir = 1'($urandom_range(1, 0));
            exp[k] = refOut(sym, dir, mPos);
            aInValid = 1'b1; aSym = sym_t'(sym); aDir = dir;
            #1;
            chk("stream_rdy", aInReady, 1);
            tick();
            chk("stream_vld", aOutValid, 1);
            chk("stream_sym", aOutSym, exp[k]);
        end
        aInValid = 1'b0;
        tick();
        chk("stream_drain", aOutValid, 0);

        bLook("b_err", 30, DIR_FWD, 0, 1);
        bWireWe = 1'b1; bAddr = 5'd30; bData = 5'd9;
        tick();
        bAddr = 5'd3; bData = 5'd28;
        tick();
        bWireWe = 1'b0;
        bLook("b_badaddr", 9, DIR_BWD, 9, 0);
        bLook("b_baddata", 3, DIR_FWD, 3, 0);
        bLook("b_last", 25, DIR_FWD, 25, 0);
        bPosWe = 1'b1; bVal = 5'd7;
        tick();
        bVal = 5'd27;
        tick();
        bPosWe = 1'b0;
        chk("b_pos7", bPos, 7);
        bOutReady = 1'b0;
        bLook("b_pending", 1, DIR_FWD, 1, 0);
        bRst = 1'b0;
        #1;
        chk("b_midrst_vld", bOutValid, 0);
        chk("b_midrst_pos", bPos, 0);
        tick();
        bRst = 1'b1;
        bOutReady = 1'b1;
        tick();
        chk("b_after_vld", bOutValid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end
endmodule
